mux_rr: RTL and testbench

MUX_RR -- requirements
Module: mux_rr

---
 rtl/mux_rr.sv | 98 +++++++++
 tb/tb_mux_rr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// N-to-1 channel multiplexer with explicit-select or round-robin grant and a single
// registered output stage with valid/ready handshakes on both sides.
module mux_rr #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            modo,
    input  logic [SELW-1:0] sinal,
    input  logic [N*W-1:0]  entrada,
    input  logic [N-1:0]    valido_in,
    output logic [N-1:0]    pronto_in,
    output logic [W-1:0]    saida,
    output logic            valido_out,
    input  logic            pronto_out,
    output logic [SELW-1:0] canal_out
);

    typedef enum logic {StVazio, StCheio} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    saida_q, saida_d;
    logic [SELW-1:0] canal_q, canal_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            load_en;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic            xfer_in;

    // Round-robin scans downward so the nearest channel after ptr wins the overwrite.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!modo) begin
            for (int i = 0; i < int'(N); i++) begin
                if (int'(sinal) == i && valido_in[i]) begin
                    grant_vld = 1'b1;
                    grant     = SELW'(i);
                end
            end
        end else begin
            for (int k = int'(N); k >= 1; k--) begin
                if (valido_in[(int'(ptr_q) + k) % int'(N)]) begin
                    grant_vld = 1'b1;
                    grant     = SELW'((int'(ptr_q) + k) % int'(N));
                end
            end
        end
    end

    // rst_n gates the accepts so nothing is offered to upstream while reset is held.
    always_comb begin
        load_en   = (state_q == StVazio) || pronto_out;
        pronto_in = '0;
        if (rst_n && load_en && grant_vld) begin
            pronto_in[grant] = 1'b1;
        end
        xfer_in = |pronto_in;
    end

    always_comb begin
        state_d = state_q;
        saida_d = saida_q;
        canal_d = canal_q;
        ptr_d   = ptr_q;
        if (xfer_in) begin
            state_d = StCheio;
            saida_d = entrada[int'(grant) * int'(W) +: W];
            canal_d = grant;
            if (modo) begin
                ptr_d = grant;
            end
        end else if (pronto_out) begin
            state_d = StVazio;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StVazio;
            saida_q <= '0;
            canal_q <= '0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            canal_q <= canal_d;
            ptr_q   <= ptr_d;
        end
    end

    assign saida      = saida_q;
    assign canal_out  = canal_q;
    assign valido_out = (state_q == StCheio);

endmodule

// File: tb/tb_mux_rr.sv
// Scoreboard bench for mux_rr: driver predicts accepts and queues expected words,
// a separate monitor compares the output register against the queue head.
`timescale 1ns/100ps
module tb_mux_rr;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            modo = 1'b0;
    logic [SELW-1:0] sinal = '0;
    logic [N*W-1:0]  entrada = '0;
    logic [N-1:0]    valido_in = '0;
    logic [N-1:0]    pronto_in;
    logic [W-1:0]    saida;
    logic            valido_out;
    logic            pronto_out = 1'b0;
    logic [SELW-1:0] canal_out;

    mux_rr #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .modo       (modo),
        .sinal      (sinal),
        .entrada    (entrada),
        .valido_in  (valido_in),
        .pronto_in  (pronto_in),
        .saida      (saida),
        .valido_out (valido_out),
        .pronto_out (pronto_out),
        .canal_out  (canal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    data;
        logic [SELW-1:0] ch;
    } item_t;

    item_t sb[$];
    int    ptr_m = N - 1;
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: straight from the selection rules, ptr kept as a plain integer.
    task automatic model_grant(output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (!modo) begin
            if (int'(sinal) < N && valido_in[sinal]) begin
                gv = 1'b1;
                g  = int'(sinal);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (!gv && valido_in[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endtask

    task automatic drive(input bit m, input logic [SELW-1:0] s, input logic [N*W-1:0] e,
                         input logic [N-1:0] v, input bit po);
        bit           gv;
        int           g;
        bit           load;
        logic [N-1:0] exp_pi;
        @(negedge clk);
        modo = m; sinal = s; entrada = e; valido_in = v; pronto_out = po;
        #1;
        model_grant(gv, g);
        load   = (sb.size() == 0) || po;
        exp_pi = (load && gv) ? (N'(1) << g) : '0;
        check("pronto_in", pronto_in, exp_pi);
        #2;
        if (load && gv) begin
            sb.push_back('{data: e[g*W +: W], ch: SELW'(g)});
            if (m) ptr_m = g;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        ptr_m = N - 1;
        modo = 1'b1; valido_in = '1; pronto_out = 1'b1;
        #2;
        check("rst_valido_out", valido_out, 0);
        check("rst_saida", saida, 0);
        check("rst_canal_out", canal_out, 0);
        check("rst_pronto_in", pronto_in, 0);
        @(negedge clk);
        valido_in = '0;
        #3 rst_n = 1'b1;
    endtask

    // Reset pulse entirely between edges; output must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        valido_in = '0; pronto_out = 1'b0;
        #3;
        rst_n = 1'b0;
        sb.delete();
        ptr_m = N - 1;
        #1;
        check("pulse_valido_out", valido_out, 0);
        check("pulse_saida", saida, 0);
        check("pulse_canal_out", canal_out, 0);
        #0.5 rst_n = 1'b1;
    endtask

    // Monitor: output register must always mirror the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check("valido_out", valido_out, (sb.size() != 0) ? 1 : 0);
                if (sb.size() != 0 && valido_out) begin
                    check("saida", saida, sb[0].data);
                    check("canal_out", canal_out, sb[0].ch);
                    if (pronto_out) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // Explicit select of channel 3.
        drive(1'b0, 3'd3, 64'h00000000_A5000000, 8'h08, 1'b1);
        drive(1'b0, 3'd0, 64'h0, 8'h00, 1'b1);

        // Round-robin over all channels starting at 0, then wrap.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 3'd0, {$urandom, $urandom}, 8'hFF, 1'b1);
        end
        drive(1'b1, 3'd0, 64'h0, 8'h00, 1'b1);

        // Only channels 0 and 7 active: alternating grants.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd0, {$urandom, $urandom}, 8'h81, 1'b1);
        end
        drive(1'b1, 3'd0, 64'h0, 8'h00, 1'b1);

        // Backpressure: held word stays put, then reloads on the draining cycle.
        drive(1'b0, 3'd2, 64'h00000000_003C0000, 8'h04, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd0, {$urandom, $urandom}, 8'hFF, 1'b0);
        end
        drive(1'b1, 3'd0, {$urandom, $urandom}, 8'hFF, 1'b1);
        drive(1'b0, 3'd0, 64'h0, 8'h00, 1'b1);

        // Selected channel idle: no accept, output stays empty.
        drive(1'b0, 3'd5, {$urandom, $urandom}, 8'hDF, 1'b1);
        drive(1'b0, 3'd5, {$urandom, $urandom}, 8'hDF, 1'b0);

        // Asynchronous reset while full, then first round-robin grant favours low channels.
        drive(1'b0, 3'd1, {$urandom, $urandom}, 8'h02, 1'b0);
        drive(1'b0, 3'd1, 64'h0, 8'h00, 1'b0);
        pulse_reset();
        drive(1'b1, 3'd0, {$urandom, $urandom}, 8'h24, 1'b1);
        drive(1'b1, 3'd0, 64'h0, 8'h00, 1'b1);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] v;
            v = (i % 3 == 0) ? N'($urandom) : N'($urandom & $urandom);
            drive(1'(($urandom % 4) == 0), SELW'($urandom), {$urandom, $urandom}, v,
                  1'(($urandom % 4) != 0));
            if (i % 400 == 399) pulse_reset();
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
